// File: rtl/shift_serializer_if.sv
// Handshake and data bundle between a word source and shift_serializer.
// The source drives load_i/code_in/shift_i. The serializer returns the serial bit,
// the live shift-register contents and its ready/busy/done status.
interface shift_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_i;
  logic [WIDTH-1:0] code_in;
  logic             shift_i;
  logic             data;
  logic [WIDTH-1:0] new_data;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (
    output load_i, code_in, shift_i,
    input  data, new_data, ready, busy, done
  );

  modport slave (
    input  load_i, code_in, shift_i,
    output data, new_data, ready, busy, done
  );
endinterface

// File: rtl/shift_serializer.sv
// Parametrised parallel-in/serial-out shift register with a load handshake.
// A word is accepted when ready=1. One bit is emitted per half_clk edge while shift_i=1.
// done pulses for one cycle after the last bit is emitted.
// MSB_FIRST selects the bit order: 0 shifts right and sends the LSB first,
// 1 shifts left and sends the MSB first.
// Optional macro SHIFT_SERIALIZER_PARITY_EN appends an even-parity bit after each word.
// The word then takes WIDTH+1 shift edges.
// Reset is synchronous and active-high.
module shift_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = $clog2(WIDTH + 2)
) (
  input logic              half_clk,
  input logic              rst,
  shift_serializer_if.slave bus
);

`ifdef SHIFT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // XOR of all bits: the value that makes the total count of ones even
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  state_t             state_r, state_nxt_s;
  logic               data_r, data_nxt_s;
  logic [WIDTH-1:0]   word_r, word_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               ready_r, ready_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  logic               parity_r, parity_nxt_s;
`endif

  // Bit leaving the register on a shift edge and the register after that shift (zero fill)
  logic               out_bit_s;
  logic [WIDTH-1:0]   shifted_s;

  // Select emitted end and shift direction from the configured bit order
  always_comb begin
    out_bit_s = 1'b0;
    shifted_s = '0;
    if (MSB_FIRST != 0) begin
      out_bit_s = word_r[WIDTH-1];
      shifted_s = {word_r[WIDTH-2:0], 1'b0};
    end else begin
      out_bit_s = word_r[0];
      shifted_s = {1'b0, word_r[WIDTH-1:1]};
    end
  end

  // Next-state and next-output logic; every register holds unless a branch changes it
  always_comb begin
    state_nxt_s  = state_r;
    data_nxt_s   = data_r;
    word_nxt_s   = word_r;
    cnt_nxt_s    = cnt_r;
    ready_nxt_s  = ready_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // A load wins over a simultaneous shift request; nothing is emitted on this edge
        if (bus.load_i) begin
          word_nxt_s   = bus.code_in;
          cnt_nxt_s    = CNT_W'(WIDTH);
          state_nxt_s  = ST_SHIFT;
          ready_nxt_s  = 1'b0;
          busy_nxt_s   = 1'b1;
`ifdef SHIFT_SERIALIZER_PARITY_EN
          parity_nxt_s = even_parity(bus.code_in);
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Emit one bit per enabled edge; shift_i low simply pauses the word
        if (bus.shift_i) begin
          data_nxt_s = out_bit_s;
          word_nxt_s = shifted_s;
          cnt_nxt_s  = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
`endif
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
`ifdef SHIFT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        // Trailing parity bit; the register is already all zeros here
        if (bus.shift_i) begin
          data_nxt_s  = parity_r;
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
          ready_nxt_s = 1'b1;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      default: begin
        // Unreachable encoding: fall back to a clean idle state
        state_nxt_s = ST_IDLE;
        word_nxt_s  = '0;
        cnt_nxt_s   = '0;
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset has priority
  always_ff @(posedge half_clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      data_r   <= 1'b0;
      word_r   <= '0;
      cnt_r    <= '0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      data_r   <= data_nxt_s;
      word_r   <= word_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ready_r  <= ready_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      parity_r <= parity_nxt_s;
`endif
    end
  end

  assign bus.data     = data_r;
  assign bus.new_data = word_r;
  assign bus.ready    = ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer (WIDTH=8).
// Two instances receive identical stimulus: one LSB-first and one MSB-first.
// A closed-form reference model (remaining-bit count plus the captured word) is
// compared with both instances on every edge. Fixed vector tables and short
// sequences cover the corner cases with hand-derived constants.
module tb_shift_serializer;
  localparam int W = 8;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  localparam int TOTAL = W + 1;
`else
  localparam int TOTAL = W;
`endif

  logic         half_clk;
  logic         rst;
  logic         load_s;
  logic [W-1:0] code_s;
  logic         shift_s;

  shift_serializer_if #(.WIDTH(W)) bus_l ();
  shift_serializer_if #(.WIDTH(W)) bus_m ();

  assign bus_l.load_i  = load_s;
  assign bus_l.code_in = code_s;
  assign bus_l.shift_i = shift_s;
  assign bus_m.load_i  = load_s;
  assign bus_m.code_in = code_s;
  assign bus_m.shift_i = shift_s;

  shift_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (.half_clk(half_clk), .rst(rst), .bus(bus_l));
  shift_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (.half_clk(half_clk), .rst(rst), .bus(bus_m));

  initial half_clk = 1'b0;
  always #5 half_clk = ~half_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model, index 0 = LSB-first, 1 = MSB-first
  int           m_rem  [2];
  logic [W-1:0] m_code [2];
  logic         m_data [2];
  logic [W-1:0] m_word [2];
  logic         m_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied
  task automatic model_update();
    int k;
    int c;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_rem[d]  = 0;
        m_data[d] = 1'b0;
        m_word[d] = '0;
        m_done[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        if (m_rem[d] == 0) begin
          if (load_s) begin
            m_code[d] = code_s;
            m_word[d] = code_s;
            m_rem[d]  = TOTAL;
          end
        end else if (shift_s) begin
          k = TOTAL - m_rem[d];
          c = int'(m_code[d]);
          if (k < W) m_data[d] = (d == 0) ? m_code[d][k] : m_code[d][W-1-k];
          else       m_data[d] = ^m_code[d];
          if (d == 0) m_word[d] = W'(c >> (k + 1));
          else        m_word[d] = W'((c << (k + 1)) & 255);
          m_rem[d] = m_rem[d] - 1;
          if (m_rem[d] == 0) m_done[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_check();
    chk("mdl_data_l",  32'(bus_l.data),     32'(m_data[0]));
    chk("mdl_word_l",  32'(bus_l.new_data), 32'(m_word[0]));
    chk("mdl_ready_l", 32'(bus_l.ready),    32'(m_rem[0] == 0));
    chk("mdl_busy_l",  32'(bus_l.busy),     32'(m_rem[0] != 0));
    chk("mdl_done_l",  32'(bus_l.done),     32'(m_done[0]));
    chk("mdl_data_m",  32'(bus_m.data),     32'(m_data[1]));
    chk("mdl_word_m",  32'(bus_m.new_data), 32'(m_word[1]));
    chk("mdl_ready_m", 32'(bus_m.ready),    32'(m_rem[1] == 0));
    chk("mdl_busy_m",  32'(bus_m.busy),     32'(m_rem[1] != 0));
    chk("mdl_done_m",  32'(bus_m.done),     32'(m_done[1]));
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic r, input logic l, input logic [W-1:0] c, input logic s);
    rst     = r;
    load_s  = l;
    code_s  = c;
    shift_s = s;
    @(posedge half_clk);
    model_update();
    #1;
    model_check();
  endtask

  typedef struct {
    logic         r;
    logic         l;
    logic [W-1:0] c;
    logic         s;
    logic         dl;
    logic [W-1:0] nl;
    logic         dm;
    logic [W-1:0] nm;
    logic         er;
    logic         eb;
    logic         ed;
  } vec_t;

  function automatic vec_t v(logic r, logic l, logic [W-1:0] c, logic s, logic dl, logic [W-1:0] nl,
                             logic dm, logic [W-1:0] nm, logic er, logic eb, logic ed);
    vec_t x;
    x = '{r, l, c, s, dl, nl, dm, nm, er, eb, ed};
    return x;
  endfunction

  vec_t tbl[$];
  logic exp_rem [5];
  int   done_cnt;

  initial begin
    rst = 1'b1; load_s = 1'b0; code_s = '0; shift_s = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_rem[d] = 0; m_code[d] = '0; m_data[d] = 1'b0; m_word[d] = '0; m_done[d] = 1'b0;
    end

    // Table: reset, load 8'hC1 together with shift_i=1, then the full word
    tbl.push_back(v(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 8'hC1, 1'b1, 1'b0, 8'hC1, 1'b0, 8'hC1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 1'b1, 8'h82, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h18, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0C, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h06, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0));
`ifdef SHIFT_SERIALIZER_PARITY_EN
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
`else
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
`endif
    tbl.push_back(v(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].c, tbl[i].s);
      chk($sformatf("tbl%0d_data_l", i),  32'(bus_l.data),     32'(tbl[i].dl));
      chk($sformatf("tbl%0d_word_l", i),  32'(bus_l.new_data), 32'(tbl[i].nl));
      chk($sformatf("tbl%0d_data_m", i),  32'(bus_m.data),     32'(tbl[i].dm));
      chk($sformatf("tbl%0d_word_m", i),  32'(bus_m.new_data), 32'(tbl[i].nm));
      chk($sformatf("tbl%0d_ready", i),   32'(bus_l.ready),    32'(tbl[i].er));
      chk($sformatf("tbl%0d_busy", i),    32'(bus_l.busy),     32'(tbl[i].eb));
      chk($sformatf("tbl%0d_done", i),    32'(bus_l.done),     32'(tbl[i].ed));
      chk($sformatf("tbl%0d_done_m", i),  32'(bus_m.done),     32'(tbl[i].ed));
    end

    // Pause and illegal load while busy
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pause_bit1", 32'(bus_l.data), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pause_bit2", 32'(bus_l.data), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pause_bit3", 32'(bus_l.data), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("pause_hold_data", 32'(bus_l.data),     32'd0);
      chk("pause_hold_word", 32'(bus_l.new_data), 32'h18);
      chk("pause_hold_busy", 32'(bus_l.busy),     32'd1);
    end
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("busy_load_word", 32'(bus_l.new_data), 32'h18);
    chk("busy_load_busy", 32'(bus_l.busy),     32'd1);
    exp_rem = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("rem_bit%0d", i), 32'(bus_l.data), 32'(exp_rem[i]));
      if (bus_l.done) done_cnt++;
    end
`ifdef SHIFT_SERIALIZER_PARITY_EN
    chk("rem_no_done_before_parity", 32'(done_cnt), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rem_parity_bit", 32'(bus_l.data), 32'd1);
    if (bus_l.done) done_cnt++;
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (bus_l.done) done_cnt++;
    end
    chk("rem_done_pulses", 32'(done_cnt), 32'd1);

    // Back-to-back: load 8'h0F (with shift_i=1) during the done cycle
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("b2b_done",  32'(bus_l.done),  32'd1);
    chk("b2b_ready", 32'(bus_l.ready), 32'd1);
    step(1'b0, 1'b1, 8'h0F, 1'b1);
    chk("b2b_busy",   32'(bus_l.busy),     32'd1);
    chk("b2b_word_l", 32'(bus_l.new_data), 32'h0F);
    chk("b2b_word_m", 32'(bus_m.new_data), 32'h0F);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("b2b_first_l", 32'(bus_l.data),     32'd1);
    chk("b2b_shift_l", 32'(bus_l.new_data), 32'h07);
    chk("b2b_first_m", 32'(bus_m.data),     32'd0);
    chk("b2b_shift_m", 32'(bus_m.new_data), 32'h1E);

    // Reset mid-word aborts without a done pulse
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("abort_data",  32'(bus_l.data),     32'd0);
    chk("abort_word",  32'(bus_l.new_data), 32'h00);
    chk("abort_ready", 32'(bus_l.ready),    32'd1);
    chk("abort_busy",  32'(bus_l.busy),     32'd0);
    chk("abort_done",  32'(bus_l.done),     32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("abort_done_after", 32'(bus_l.done),  32'd0);
    chk("abort_idle_after", 32'(bus_l.ready), 32'd1);

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), W'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
